// File: rtl/bs_pipe_shift_rotate.sv
// Pipelined barrel shifter: rotate, logical shift or arithmetic shift by 0..WIDTH-1.
// One registered stage per shift-amount bit, with valid/ready flow control on both sides.
module bs_pipe_shift_rotate #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [SHW-1:0]   i_amt,
    input  logic             i_left,
    input  logic [1:0]       i_mode,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    typedef enum logic [1:0] {
        MODE_ROT = 2'b00,
        MODE_LSH = 2'b01,
        MODE_ASH = 2'b10,
        MODE_LSX = 2'b11
    } mode_e;

    // Per-stage registered state
    logic [SHW-1:0]   valid_q;
    logic [WIDTH-1:0] data_q [SHW];
    logic [SHW-1:0]   amt_q  [SHW];
    logic [1:0]       mode_q [SHW];
    logic [SHW-1:0]   left_q;
    logic [SHW-1:0]   sign_q;

    // Per-stage inputs (stage 0 from ports, stage k from stage k-1)
    logic [SHW-1:0]   in_valid;
    logic [WIDTH-1:0] in_data [SHW];
    logic [SHW-1:0]   in_amt  [SHW];
    logic [1:0]       in_mode [SHW];
    logic [SHW-1:0]   in_left;
    logic [SHW-1:0]   in_sign;
    logic [WIDTH-1:0] next_data [SHW];
    logic [SHW-1:0]   load;

    // Shift or rotate a word by a fixed stage distance s (1 <= s < WIDTH).
    // Left arithmetic falls through to zero fill; only right arithmetic uses the sign bit.
    function automatic logic [WIDTH-1:0] stage_op(
        input logic [WIDTH-1:0] d,
        input int unsigned      s,
        input logic             left,
        input logic [1:0]       mode,
        input logic             sign
    );
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] r;
        ones = '1;
        if (left) begin
            r = d << s;
            if (mode == MODE_ROT) r = r | (d >> (WIDTH - s));
        end else begin
            r = d >> s;
            if (mode == MODE_ROT) r = r | (d << (WIDTH - s));
            else if (mode == MODE_ASH && sign) r = r | ~(ones >> s);
        end
        return r;
    endfunction

    // Route each stage's input and compute its conditional shift by 2^k
    always_comb begin
        in_valid   = '0;
        in_left    = '0;
        in_sign    = '0;
        in_valid[0] = i_valid;
        in_data[0]  = i_data;
        in_amt[0]   = i_amt;
        in_mode[0]  = i_mode;
        in_left[0]  = i_left;
        in_sign[0]  = i_data[WIDTH-1];
        for (int unsigned k = 1; k < SHW; k++) begin
            in_valid[k] = valid_q[k-1];
            in_data[k]  = data_q[k-1];
            in_amt[k]   = amt_q[k-1];
            in_mode[k]  = mode_q[k-1];
            in_left[k]  = left_q[k-1];
            in_sign[k]  = sign_q[k-1];
        end
        for (int unsigned k = 0; k < SHW; k++) begin
            if (in_amt[k][0])
                next_data[k] = stage_op(in_data[k], 32'd1 << k, in_left[k], in_mode[k], in_sign[k]);
            else
                next_data[k] = in_data[k];
        end
    end

    // Stage k may load when downstream is ready or any stage from k to the end is empty;
    // written as a reduction rather than a chained recurrence so no signal feeds itself.
    always_comb begin
        load = '0;
        for (int unsigned k = 0; k < SHW; k++) begin
            logic full;
            full = 1'b1;
            for (int unsigned j = k; j < SHW; j++) full = full & valid_q[j];
            load[k] = i_ready | ~full;
        end
    end

    // Pipeline registers; payload only captured for valid words, bubbles leave it untouched
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
            left_q  <= '0;
            sign_q  <= '0;
            for (int unsigned k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < SHW; k++) begin
                if (load[k]) begin
                    valid_q[k] <= in_valid[k];
                    if (in_valid[k]) begin
                        data_q[k] <= next_data[k];
                        amt_q[k]  <= in_amt[k] >> 1;
                        mode_q[k] <= in_mode[k];
                        left_q[k] <= in_left[k];
                        sign_q[k] <= in_sign[k];
                    end
                end
            end
        end
    end

    assign o_ready = load[0];
    assign o_valid = valid_q[SHW-1];
    assign o_data  = data_q[SHW-1];

endmodule
